// File: rtl/text_term_ctrl.sv
// Terminal controller: ASCII stream to 8x8 text buffer writes, cursor, scroll.
// Optional auto-clear after reset: TEXT_CLEAR_ON_RESET_EN.
module text_term_ctrl #(
  parameter int h_disp = 1280,
  parameter int v_disp = 1024,
  localparam int COLS = h_disp / 8,
  localparam int ROWS = v_disp / 8,
  localparam int addr_width = $clog2(COLS * ROWS),
  localparam int col_width = $clog2(COLS),
  localparam int row_width = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_char,
  output logic                  in_ready,
  output logic [addr_width-1:0] addr_write,
  output logic [7:0]            char_write,
  output logic                  write_enable,
  output logic [row_width-1:0]  top_row,
  output logic [col_width-1:0]  cursor_col,
  output logic [row_width-1:0]  cursor_row,
  output logic                  busy
);

  localparam logic [col_width-1:0] COL_LAST = col_width'(COLS - 1);
  localparam logic [row_width-1:0] ROW_LAST = row_width'(ROWS - 1);
  localparam logic [row_width:0] ROWS_W = (row_width + 1)'(ROWS);
  localparam logic [addr_width-1:0] ROW_CNT_LAST = addr_width'(COLS - 1);
  localparam logic [addr_width-1:0] CELL_LAST = addr_width'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } state_e;

  state_e state_q, state_d;
  logic run_q, run_d;
  logic [row_width-1:0] top_q, top_d;
  logic [row_width-1:0] row_q, row_d;
  logic [col_width-1:0] col_q, col_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [7:0] chr_q, chr_d;
  logic nl;
  logic printable;

  // Row wrap by compare so non-power-of-2 row counts work.
  function automatic logic [addr_width-1:0] phys(
    input logic [row_width-1:0] t,
    input logic [row_width-1:0] r,
    input logic [col_width-1:0] c
  );
    logic [row_width:0] s;
    s = {1'b0, t} + {1'b0, r};
    if (s >= ROWS_W) s = s - ROWS_W;
    return addr_width'(s) * addr_width'(COLS) + addr_width'(c);
  endfunction

  assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign in_ready = run_q && (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign write_enable = we_q;
  assign addr_write = addr_q;
  assign char_write = chr_q;
  assign top_row = top_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // Next state: byte decode, cursor motion, scroll and clear sequencing.
  always_comb begin
    state_d = state_q;
    run_d = 1'b1;
    top_d = top_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    addr_d = addr_q;
    chr_d = chr_q;
    nl = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!run_q) begin
`ifdef TEXT_CLEAR_ON_RESET_EN
          state_d = CLR_ALL;
          cnt_d = '0;
`else
          state_d = IDLE;
`endif
        end else if (in_valid) begin
          unique case (1'b1)
            printable: begin
              we_d = 1'b1;
              addr_d = phys(top_q, row_q, col_q);
              chr_d = in_char;
              if (col_q == COL_LAST) nl = 1'b1;
              else col_d = col_q + 1'b1;
            end
            (in_char == 8'h0A): nl = 1'b1;
            (in_char == 8'h0D): col_d = '0;
            (in_char == 8'h08): begin
              if (col_q != '0) begin
                col_d = col_q - 1'b1;
                we_d = 1'b1;
                addr_d = phys(top_q, row_q, col_q - 1'b1);
                chr_d = 8'h20;
              end
            end
            (in_char == 8'h0C): begin
              state_d = CLR_ALL;
              cnt_d = '0;
              top_d = '0;
              row_d = '0;
              col_d = '0;
            end
            default: ;
          endcase
          if (nl) begin
            col_d = '0;
            if (row_q != ROW_LAST) begin
              row_d = row_q + 1'b1;
            end else begin
              top_d = (top_q == ROW_LAST) ? '0 : top_q + 1'b1;
              state_d = CLR_ROW;
              cnt_d = '0;
            end
          end
        end
      end
      CLR_ROW: begin
        we_d = 1'b1;
        chr_d = 8'h20;
        addr_d = phys(top_q, row_q, cnt_q[col_width-1:0]);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ROW_CNT_LAST) state_d = IDLE;
      end
      CLR_ALL: begin
        we_d = 1'b1;
        chr_d = 8'h20;
        addr_d = cnt_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CELL_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q <= 1'b0;
      top_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      chr_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      top_q <= top_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      chr_q <= chr_d;
    end
  end

endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
Character-stream terminal controller that drives the write port of the 8x8-cell text buffer. It accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It turns printable characters and control codes into buffer writes, and implements scrolling with a hardware top-row offset. The offset is exported to the display read path, so scrolling never copies memory.

Parameters:
h_disp, 1280, horizontal resolution in pixels; COLS = h_disp/8 (160)
v_disp, 1024, vertical resolution in pixels; ROWS = v_disp/8 (128)
addr_width (localparam), $clog2(COLS*ROWS) (15), text buffer address width
col_width (localparam), $clog2(COLS) (8)
row_width (localparam), $clog2(ROWS) (7)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_char valid
in_char  input  8  ASCII byte
in_ready  output  1  controller can accept a byte this cycle
addr_write  output  addr_width  text buffer write address
char_write  output  8  text buffer write data
write_enable  output  1  text buffer write strobe
top_row  output  row_width  physical buffer row shown at screen row 0; display reader adds this mod ROWS
cursor_col  output  col_width  current cursor column
cursor_row  output  row_width  current logical cursor row (0 = top of screen)
busy  output  1  clear sequence in progress

Behaviour:
- Reset values (async, rst_n low): write_enable=0, addr_write=0, char_write=0, top_row=0, cursor_col=0, cursor_row=0, busy=0, in_ready=0. State returns to IDLE.
- Physical address of a logical cell (r,c): ((top_row+r) mod ROWS)*COLS + c. Row wrap uses explicit compare, not power-of-2 truncation.
- States:
  - IDLE: in_ready=1.
  - CLR_ROW: in_ready=0, busy=1.
  - CLR_ALL: in_ready=0, busy=1.
- A byte is accepted when in_valid && in_ready. All writes are registered: write_enable pulses 1 cycle, one cycle after acceptance.
- Printable (0x20..0x7E):
  - Write the byte at the cursor, then col++.
  - If col was COLS-1, perform NEWLINE instead of the increment; the write still happens at column COLS-1.
- 0x0A NEWLINE:
  - col=0.
  - If row<ROWS-1: row++, stay IDLE.
  - Else (row==ROWS-1): top_row=(top_row+1) mod ROWS, row stays ROWS-1, enter CLR_ROW.
- 0x0D CR: col=0; no write.
- 0x08 BS:
  - If col>0: col--, and write 0x20 at the new position.
  - At col 0: no-op; no reverse row wrap.
- 0x0C FF: enter CLR_ALL; cursor=(0,0); top_row=0.
- All other bytes: accepted and ignored, with no write and no cursor change.
- CLR_ROW:
  - Writes 0x20 to cols 0..COLS-1 of the new bottom logical row, one per cycle, in column order.
  - COLS consecutive write_enable cycles, then return to IDLE.
  - in_ready returns to 1 the cycle after the last write.
- CLR_ALL:
  - Writes 0x20 to physical addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - Then IDLE.
- No input is lost: in_ready=0 throughout a clear, so a held in_valid stalls.
- Reset mid-clear: the clear is abandoned immediately, with no further writes and all registers at reset values. Buffer contents are undefined except for cells already written.
- write_enable is never high for two sources in the same cycle. At most one write per cycle.

Optional Feature:
TEXT_CLEAR_ON_RESET_EN
- Defined: after rst_n deasserts, the controller enters CLR_ALL automatically. It writes COLS*ROWS spaces with busy=1 and in_ready=0, then enters IDLE.
- Undefined: the controller enters IDLE directly after reset, with in_ready=1 on the first clock after rst_n rises. Buffer contents are left as-is.

Test Plan:
- Reset, then send 'A' (0x41) at (0,0) -> the next cycle shows write_enable=1, addr_write=0, char_write=0x41; then cursor_col=1.
- Send 160 x 'B' from (0,0) -> last write at addr 159; then cursor=(row1,col0); top_row=0; no clear.
- Move the cursor to row 127 with 127 x 0x0A, then send 0x0A -> top_row=1, busy=1 for exactly 160 cycles writing 0x20 to addrs 0..159, then in_ready=1, cursor=(127,0).
- At (0,5) send 0x08 -> write 0x20 at addr 4, cursor_col=4. Send 0x0D -> col=0, no write. Send 0x08 at col 0 -> no write, cursor unchanged.
- Send 0x0C with in_valid held high carrying 'C' afterwards -> 20480 writes of 0x20 at addrs 0..20479, in_ready=0 throughout. 'C' is then written at addr 0; top_row=0.
- Assert rst_n=0 midway through a CLR_ALL (after 100 writes) -> write_enable=0 immediately and outputs at reset values. With TEXT_CLEAR_ON_RESET_EN, the full 20480-write clear restarts after release.
